// File: rtl/sdram_rd_uart_tx_pkg.sv
// Shared types and UART frame constants for the
// SDRAM read-back path (transmitter and receiver).
package sdram_rd_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } tx_state_e;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  function automatic int baud_max(
    input int clk_freq,
    input int bps
  );
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/sdram_rd_uart_tx_if.sv
// Read-FIFO bus between the SDRAM read side
// and the UART transmitter.
interface sdram_rd_uart_tx_if;

  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_MAX-1 while
// clr is low and flags the last clock of each bit.
module uart_baud_cnt #(
  parameter int BAUD_MAX = 52
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end
);

  localparam int W = $clog2(BAUD_MAX);
  localparam logic [W-1:0] LAST = W'(BAUD_MAX - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = !clr && cnt == LAST;

endmodule

// File: rtl/sdram_rd_uart_tx.sv
// Drains DATA_NUM bytes from the read FIFO per start
// request and sends them on tx as 8N1 frames.
module sdram_rd_uart_tx
  import sdram_rd_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600,
  parameter int DATA_NUM = 10
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  sdram_rd_uart_tx_if.master fifo,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int BAUD_MAX =
    baud_max(CLK_FREQ, UART_BPS);
  localparam logic [9:0] LAST_BYTE =
    10'(DATA_NUM - 1);
  localparam logic [3:0] LAST_BIT =
    4'(FRAME_BITS - 1);

  tx_state_e  state;
  tx_state_e  state_nxt;
  logic [3:0] bit_cnt;
  logic [9:0] byte_cnt;
  logic [7:0] shift;
  logic       baud_clr;
  logic       bit_end;
  logic       frame_end;
  logic       last_byte;

  assign baud_clr  = state != SEND;
  assign frame_end = bit_end && bit_cnt == LAST_BIT;
  assign last_byte = byte_cnt == LAST_BYTE;

  uart_baud_cnt #(
    .BAUD_MAX (BAUD_MAX)
  ) u_baud (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: if (!fifo.fifo_empty) state_nxt = LOAD;
      LOAD:  state_nxt = SEND;
      SEND:  if (frame_end) begin
        state_nxt = last_byte ? DONE : FETCH;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo.fifo_rd_en = state == FETCH && !fifo.fifo_empty;
    busy            = state != IDLE;
    done            = state == DONE;
  end

  // tx is loaded one bit ahead so the pin changes on
  // the first clock of each bit period.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= 8'hFF;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start) byte_cnt <= '0;
        end
        LOAD: begin
          shift   <= fifo.fifo_rd_data;
          bit_cnt <= '0;
          tx      <= START_BIT;
        end
        SEND: begin
          if (frame_end) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
            if (!last_byte) byte_cnt <= byte_cnt + 10'd1;
          end else if (bit_end) begin
            bit_cnt <= bit_cnt + 4'd1;
            tx <= (bit_cnt == 4'd8) ? STOP_BIT
                                    : shift[bit_cnt[2:0]];
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule
